// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one ALU between two requesters. Requester 0 is the multi-cycle
// datapath control, requester 1 an auxiliary unit (address / branch target).
// One request is granted at a time, its operands are held on SrcA/SrcB/
// ALUControl for a single EXEC cycle, and the ALU outputs are captured into a
// response register tagged with the requester id.
//
// Handshakes: every valid/ready pair transfers on a rising clk edge where
// both valid and ready are high. A producer may drop valid before ready is
// seen; nothing is recorded in that case. A response is held unchanged while
// resp_valid is high and resp_ready is low.
//
// Optional build macro:
//   ALU_ARB_FIXED_PRIO_EN  requester 0 always wins simultaneous requests.
//                          Undefined (default): round-robin on last grant.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req0_* / req1_*          valid, ready, a, b, op of each requester
//   SrcA, SrcB, ALUControl   operands/op to the ALU (hold last issued value)
//   ALUResult, Zero, sign    results from the ALU
//   resp_valid, resp_ready   response handshake
//   resp_id                  requester owning the response
//   resp_result/zero/sign    captured ALU outputs
//   dbg_state_o              current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [OPW-1:0]   ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             Zero,
    input  logic             sign,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_sign,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             id_q, id_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic             resp_zero_q, resp_zero_d;
    logic             resp_sign_q, resp_sign_d;

    logic             grant_any;
    logic             grant_id;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 wins any contest; no grant history needed.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = ~req0_valid;
    end
`else
    logic last_grant_q, last_grant_d;

    // On a contest the requester not served last wins. A lone valid wins
    // regardless of history.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
    end
`endif

    // Next-state and outputs.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        id_d          = id_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        resp_sign_d   = resp_sign_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d  = last_grant_q;
`endif
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                req0_ready = grant_any & ~grant_id;
                req1_ready = grant_any &  grant_id;
                if (grant_any) begin
                    a_d     = grant_id ? req1_a  : req0_a;
                    b_d     = grant_id ? req1_b  : req0_b;
                    op_d    = grant_id ? req1_op : req0_op;
                    id_d    = grant_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant_d = grant_id;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Operand registers feed the ALU directly, so its outputs
                // are settled by the end of this single cycle.
                resp_result_d = ALUResult;
                resp_zero_d   = Zero;
                resp_sign_d   = sign;
                resp_id_d     = id_q;
                resp_valid_d  = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            id_q          <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_sign_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            // Requester 0 wins the first contest after reset.
            last_grant_q  <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            id_q          <= id_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
            resp_sign_q   <= resp_sign_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    // ALU inputs keep the last issued operands outside EXEC.
    assign SrcA        = a_q;
    assign SrcB        = b_q;
    assign ALUControl  = op_q;

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_sign   = resp_sign_q;
    assign dbg_state_o = state_q;

endmodule
